// File: rtl/mri_sequencer.sv
// mri_sequencer: hardwired T0..T5 fetch/decode/execute control for the accumulator datapath
module mri_sequencer #(
    parameter int CNT_W  = 16,
    parameter bit IND_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic [15:0]      ir_in,
    output logic [2:0]       bus_sel,
    output logic             ar_ld,
    output logic             ar_inr,
    output logic             pc_ld,
    output logic             pc_inr,
    output logic             ir_ld,
    output logic             dr_ld,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ac_ld,
    output logic             ac_and,
    output logic             ac_add,
    output logic             ac_dr,
    output logic [2:0]       t_state,
    output logic             running,
    output logic             halted,
    output logic             ill_op,
    output logic [CNT_W-1:0] instr_cnt
);
    typedef enum logic [3:0] {IDLE, T0, T1, T2, T3, T4, T5, HALT} state_t;

    state_t     state, state_nxt;
    logic [2:0] d;
    logic       i_bit, retire, hlt, go, ill_set;
    logic       unused_ir;

    assign d         = ir_in[14:12];
    assign i_bit     = ir_in[15];
    assign unused_ir = ^ir_in[11:1];
    assign running   = (state >= T0) && (state <= T5);
    assign halted    = state == HALT;
    assign t_state   = running ? 3'(state - T0) : 3'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ill_op    <= 1'b0;
            instr_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (go)
                ill_op <= 1'b0;
            else if (ill_set)
                ill_op <= 1'b1;
            if (retire)
                instr_cnt <= instr_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        bus_sel   = 3'b000;
        ar_ld     = 1'b0;
        ar_inr    = 1'b0;
        pc_ld     = 1'b0;
        pc_inr    = 1'b0;
        ir_ld     = 1'b0;
        dr_ld     = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        ac_ld     = 1'b0;
        ac_and    = 1'b0;
        ac_add    = 1'b0;
        ac_dr     = 1'b0;
        retire    = 1'b0;
        hlt       = 1'b0;
        go        = 1'b0;
        ill_set   = 1'b0;
        case (state)
            IDLE, HALT: begin
                go        = start && !stop;
                state_nxt = go ? T0 : state;
            end
            T0: begin
                bus_sel   = 3'b010;
                ar_ld     = 1'b1;
                state_nxt = T1;
            end
            T1: begin
                bus_sel   = 3'b111;
                mem_read  = 1'b1;
                ir_ld     = 1'b1;
                pc_inr    = 1'b1;
                state_nxt = T2;
            end
            T2: begin
                bus_sel   = 3'b101;
                ar_ld     = 1'b1;
                state_nxt = T3;
            end
            T3: begin
                if (d == 3'd7) begin
                    retire = 1'b1;
                    hlt    = !i_bit && ir_in[0];
                end else begin
                    // indirect: AR <- M[AR] before the operand access
                    if (i_bit && IND_EN) begin
                        bus_sel  = 3'b111;
                        mem_read = 1'b1;
                        ar_ld    = 1'b1;
                    end
                    state_nxt = T4;
                end
            end
            T4: begin
                if (d <= 3'd2) begin
                    bus_sel   = 3'b111;
                    mem_read  = 1'b1;
                    dr_ld     = 1'b1;
                    state_nxt = T5;
                end else begin
                    retire = 1'b1;
                    if (d == 3'd3) begin
                        bus_sel   = 3'b100;
                        mem_write = 1'b1;
                    end else if (d == 3'd4) begin
                        bus_sel = 3'b001;
                        pc_ld   = 1'b1;
                    end else begin
                        ill_set = 1'b1;
                    end
                end
            end
            T5: begin
                ac_ld  = 1'b1;
                ac_and = d == 3'd0;
                ac_add = d == 3'd1;
                ac_dr  = d == 3'd2;
                retire = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
        if (retire)
            state_nxt = hlt ? HALT : stop ? IDLE : T0;
    end
endmodule

// File: tb/tb_mri_sequencer.sv
// tb_mri_sequencer: directed program run on a behavioural AR/PC/IR/DR/AC/memory datapath
module tb_mri_sequencer;
    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, stop = 1'b0;
    logic [2:0]  bus_sel, t_state;
    logic        ar_ld, ar_inr, pc_ld, pc_inr, ir_ld, dr_ld, mem_read, mem_write;
    logic        ac_ld, ac_and, ac_add, ac_dr, running, halted, ill_op;
    logic [15:0] instr_cnt;
    logic [2:0]  bus_sel2, t_state2;
    logic        ar_ld2, ar_inr2, pc_ld2, pc_inr2, ir_ld2, dr_ld2, mem_read2, mem_write2;
    logic        ac_ld2, ac_and2, ac_add2, ac_dr2, running2, halted2, ill_op2;
    logic [1:0]  instr_cnt2;

    logic [11:0] ar = 12'h0, pc = 12'h0;
    logic [15:0] ir = 16'h0, dr = 16'h0, ac = 16'h0, bus;
    logic [15:0] mem [0:4095] = '{12'h000: 16'h2010, 12'h001: 16'h9020, 12'h002: 16'h4100,
                                  12'h010: 16'h0005, 12'h020: 16'h0030, 12'h030: 16'h0003,
                                  12'h100: 16'h5000, 12'h101: 16'h7001, 12'h102: 16'h1010,
                                  12'h103: 16'h3040, 12'h104: 16'h3040, default: 16'h0000};

    int vec = 0, errs = 0;

    localparam logic [14:0] S_T0  = 15'b010_1000_0000_0000;
    localparam logic [14:0] S_T1  = 15'b111_0001_1010_0000;
    localparam logic [14:0] S_T2  = 15'b101_1000_0000_0000;
    localparam logic [14:0] S_T3I = 15'b111_1000_0010_0000;
    localparam logic [14:0] S_RD  = 15'b111_0000_0110_0000;
    localparam logic [14:0] S_STA = 15'b100_0000_0001_0000;
    localparam logic [14:0] S_BUN = 15'b001_0010_0000_0000;
    localparam logic [14:0] S_LDA = 15'b000_0000_0000_1001;
    localparam logic [14:0] S_ADD = 15'b000_0000_0000_1010;
    localparam logic [19:0] O_IDLE = 20'h0;
    localparam logic [19:0] O_HALT = {2'b01, 3'd0, 15'd0};
    localparam logic [19:0] O_T0   = {2'b10, 3'd0, S_T0};

    logic [19:0] obs;
    assign obs = {running, halted, t_state, bus_sel, ar_ld, ar_inr, pc_ld, pc_inr,
                  ir_ld, dr_ld, mem_read, mem_write, ac_ld, ac_and, ac_add, ac_dr};

    mri_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .ir_in(ir),
        .bus_sel(bus_sel), .ar_ld(ar_ld), .ar_inr(ar_inr), .pc_ld(pc_ld), .pc_inr(pc_inr),
        .ir_ld(ir_ld), .dr_ld(dr_ld), .mem_read(mem_read), .mem_write(mem_write),
        .ac_ld(ac_ld), .ac_and(ac_and), .ac_add(ac_add), .ac_dr(ac_dr),
        .t_state(t_state), .running(running), .halted(halted), .ill_op(ill_op),
        .instr_cnt(instr_cnt)
    );

    mri_sequencer #(.CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .ir_in(ir),
        .bus_sel(bus_sel2), .ar_ld(ar_ld2), .ar_inr(ar_inr2), .pc_ld(pc_ld2), .pc_inr(pc_inr2),
        .ir_ld(ir_ld2), .dr_ld(dr_ld2), .mem_read(mem_read2), .mem_write(mem_write2),
        .ac_ld(ac_ld2), .ac_and(ac_and2), .ac_add(ac_add2), .ac_dr(ac_dr2),
        .t_state(t_state2), .running(running2), .halted(halted2), .ill_op(ill_op2),
        .instr_cnt(instr_cnt2)
    );

    always #5 clk = ~clk;

    always_comb begin
        case (bus_sel)
            3'b001:  bus = {4'h0, ar};
            3'b010:  bus = {4'h0, pc};
            3'b011:  bus = dr;
            3'b100:  bus = ac;
            3'b101:  bus = ir;
            3'b111:  bus = mem[ar];
            default: bus = 16'h0;
        endcase
    end

    always @(posedge clk) begin
        if (ar_ld) ar <= bus[11:0]; else if (ar_inr) ar <= ar + 12'd1;
        if (pc_ld) pc <= bus[11:0]; else if (pc_inr) pc <= pc + 12'd1;
        if (ir_ld) ir <= bus;
        if (dr_ld) dr <= bus;
        if (ac_ld) ac <= ac_and ? (ac & dr) : ac_add ? (ac + dr) : dr;
        if (mem_write) mem[ar] <= bus;
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        #2;
        vec++; if (obs !== O_IDLE) begin errs++; $display("FAIL reset_obs: got %h want %h", obs, O_IDLE); end
        vec++; if (instr_cnt !== 16'd0) begin errs++; $display("FAIL reset_cnt: got %h want 0", instr_cnt); end
        vec++; if (ill_op !== 1'b0) begin errs++; $display("FAIL reset_ill: got %b want 0", ill_op); end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        vec++; if (obs !== O_IDLE) begin errs++; $display("FAIL idle_hold: got %h want %h", obs, O_IDLE); end
    endtask

    task automatic test_lda();
        logic [19:0] e [6];
        e = '{O_T0, {2'b10, 3'd1, S_T1}, {2'b10, 3'd2, S_T2}, {2'b10, 3'd3, 15'd0},
              {2'b10, 3'd4, S_RD}, {2'b10, 3'd5, S_LDA}};
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            vec++; if (obs !== e[i]) begin errs++; $display("FAIL lda_t%0d: got %h want %h", i, obs, e[i]); end
            step();
        end
        vec++; if (ac !== 16'h0005) begin errs++; $display("FAIL lda_ac: got %h want 0005", ac); end
        vec++; if (instr_cnt !== 16'd1) begin errs++; $display("FAIL lda_cnt: got %0d want 1", instr_cnt); end
        vec++; if (obs !== O_T0) begin errs++; $display("FAIL lda_next: got %h want %h", obs, O_T0); end
    endtask

    task automatic test_add_indirect();
        logic [19:0] e [6];
        e = '{O_T0, {2'b10, 3'd1, S_T1}, {2'b10, 3'd2, S_T2}, {2'b10, 3'd3, S_T3I},
              {2'b10, 3'd4, S_RD}, {2'b10, 3'd5, S_ADD}};
        for (int i = 0; i < 6; i++) begin
            vec++; if (obs !== e[i]) begin errs++; $display("FAIL addi_t%0d: got %h want %h", i, obs, e[i]); end
            step();
        end
        vec++; if (ac !== 16'h0008) begin errs++; $display("FAIL addi_ac: got %h want 0008", ac); end
        vec++; if (instr_cnt !== 16'd2) begin errs++; $display("FAIL addi_cnt: got %0d want 2", instr_cnt); end
    endtask

    task automatic test_bun();
        logic [19:0] e [5];
        e = '{O_T0, {2'b10, 3'd1, S_T1}, {2'b10, 3'd2, S_T2}, {2'b10, 3'd3, 15'd0},
              {2'b10, 3'd4, S_BUN}};
        for (int i = 0; i < 5; i++) begin
            vec++; if (obs !== e[i]) begin errs++; $display("FAIL bun_t%0d: got %h want %h", i, obs, e[i]); end
            step();
        end
        vec++; if (pc !== 12'h100) begin errs++; $display("FAIL bun_pc: got %h want 100", pc); end
        vec++; if (instr_cnt !== 16'd3) begin errs++; $display("FAIL bun_cnt: got %0d want 3", instr_cnt); end
        vec++; if (obs !== O_T0) begin errs++; $display("FAIL bun_next: got %h want %h", obs, O_T0); end
    endtask

    task automatic test_illegal();
        logic [19:0] e [5];
        e = '{O_T0, {2'b10, 3'd1, S_T1}, {2'b10, 3'd2, S_T2}, {2'b10, 3'd3, 15'd0},
              {2'b10, 3'd4, 15'd0}};
        for (int i = 0; i < 5; i++) begin
            vec++; if (obs !== e[i]) begin errs++; $display("FAIL ill_t%0d: got %h want %h", i, obs, e[i]); end
            step();
        end
        vec++; if (ir !== 16'h5000) begin errs++; $display("FAIL ill_fetch: got %h want 5000", ir); end
        vec++; if (ill_op !== 1'b1) begin errs++; $display("FAIL ill_set: got %b want 1", ill_op); end
        vec++; if (instr_cnt !== 16'd4) begin errs++; $display("FAIL ill_cnt: got %0d want 4", instr_cnt); end
        vec++; if (instr_cnt2 !== 2'd0) begin errs++; $display("FAIL cnt_wrap: got %0d want 0", instr_cnt2); end
        vec++; if (obs !== O_T0) begin errs++; $display("FAIL ill_next: got %h want %h", obs, O_T0); end
    endtask

    task automatic test_hlt();
        logic [19:0] e [4];
        e = '{O_T0, {2'b10, 3'd1, S_T1}, {2'b10, 3'd2, S_T2}, {2'b10, 3'd3, 15'd0}};
        for (int i = 0; i < 4; i++) begin
            vec++; if (obs !== e[i]) begin errs++; $display("FAIL hlt_t%0d: got %h want %h", i, obs, e[i]); end
            step();
        end
        vec++; if (obs !== O_HALT) begin errs++; $display("FAIL hlt_state: got %h want %h", obs, O_HALT); end
        vec++; if (instr_cnt !== 16'd5) begin errs++; $display("FAIL hlt_cnt: got %0d want 5", instr_cnt); end
        step();
        vec++; if (obs !== O_HALT) begin errs++; $display("FAIL hlt_hold: got %h want %h", obs, O_HALT); end
        vec++; if (ill_op !== 1'b1) begin errs++; $display("FAIL ill_sticky: got %b want 1", ill_op); end
        start = 1'b1; step(); start = 1'b0;
        vec++; if (obs !== O_T0) begin errs++; $display("FAIL hlt_resume: got %h want %h", obs, O_T0); end
        vec++; if (ill_op !== 1'b0) begin errs++; $display("FAIL ill_clear: got %b want 0", ill_op); end
        vec++; if (pc !== 12'h102) begin errs++; $display("FAIL hlt_pc: got %h want 102", pc); end
    endtask

    task automatic test_stop();
        logic [19:0] e [6];
        e = '{O_T0, {2'b10, 3'd1, S_T1}, {2'b10, 3'd2, S_T2}, {2'b10, 3'd3, 15'd0},
              {2'b10, 3'd4, S_RD}, {2'b10, 3'd5, S_ADD}};
        for (int i = 0; i < 6; i++) begin
            vec++; if (obs !== e[i]) begin errs++; $display("FAIL stop_t%0d: got %h want %h", i, obs, e[i]); end
            if (i == 1) stop = 1'b1;
            step();
        end
        vec++; if (obs !== O_IDLE) begin errs++; $display("FAIL stop_idle: got %h want %h", obs, O_IDLE); end
        vec++; if (ac !== 16'h000d) begin errs++; $display("FAIL stop_ac: got %h want 000d", ac); end
        vec++; if (instr_cnt !== 16'd6) begin errs++; $display("FAIL stop_cnt: got %0d want 6", instr_cnt); end
        start = 1'b1; step(); step();
        vec++; if (obs !== O_IDLE) begin errs++; $display("FAIL stop_prio: got %h want %h", obs, O_IDLE); end
        start = 1'b0; stop = 1'b0;
    endtask

    task automatic test_reset_mid_sta();
        logic [19:0] e [5];
        e = '{O_T0, {2'b10, 3'd1, S_T1}, {2'b10, 3'd2, S_T2}, {2'b10, 3'd3, 15'd0},
              {2'b10, 3'd4, S_STA}};
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            vec++; if (obs !== e[i]) begin errs++; $display("FAIL sta_t%0d: got %h want %h", i, obs, e[i]); end
            if (i < 4) step();
        end
        rst_n = 1'b0;
        #1;
        vec++; if (mem_write !== 1'b0) begin errs++; $display("FAIL rst_memwr: got %b want 0", mem_write); end
        vec++; if (obs !== O_IDLE) begin errs++; $display("FAIL rst_obs: got %h want %h", obs, O_IDLE); end
        vec++; if (instr_cnt !== 16'd0) begin errs++; $display("FAIL rst_cnt: got %0d want 0", instr_cnt); end
        step();
        vec++; if (mem[12'h040] !== 16'h0000) begin errs++; $display("FAIL rst_abort: got %h want 0000", mem[12'h040]); end
        rst_n = 1'b1;
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 5; i++) step();
        vec++; if (mem[12'h040] !== 16'h000d) begin errs++; $display("FAIL sta_mem: got %h want 000d", mem[12'h040]); end
        vec++; if (instr_cnt !== 16'd1) begin errs++; $display("FAIL sta_cnt: got %0d want 1", instr_cnt); end
        vec++; if (obs !== O_T0) begin errs++; $display("FAIL sta_next: got %h want %h", obs, O_T0); end
    endtask

    initial begin
        test_reset();
        test_lda();
        test_add_indirect();
        test_bun();
        test_illegal();
        test_hlt();
        test_stop();
        test_reset_mid_sta();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
